// File: rtl/bp_pkg.sv
// bp_pkg: shared 2-bit saturating counter encoding and update helper for the branch predictor.
package bp_pkg;
    localparam int CNT_W = 2;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;
    localparam cnt_t CNT_RST = CNT_WNT;

    function automatic cnt_t cnt_update(input cnt_t c, input logic taken);
        return taken ? ((c == CNT_ST) ? c : c + 2'd1) : ((c == CNT_SNT) ? c : c - 2'd1);
    endfunction
endpackage

// File: rtl/branch_predictor_bht.sv
// branch_history_table: array of 2-bit counters, async read, sync saturating write.
// A read and write to the same entry in one cycle returns the old value.
module branch_history_table
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output cnt_t                  rd_cnt_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic                  taken_i
);
    localparam int DEPTH = 1 << INDEX_BITS;

    cnt_t table_q [DEPTH];
    cnt_t cnt_d;

    assign rd_cnt_o = table_q[rd_idx_i];
    assign cnt_d    = cnt_update(table_q[wr_idx_i], taken_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= CNT_RST;
        end else if (we_i) begin
            table_q[wr_idx_i] <= cnt_d;
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: gshare-indexed 2-bit counter predictor producing the F-stage next PC
// and the D-stage correction PC; history is updated only at resolution.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int PC_STEP    = 1,
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 4,
    parameter int GSHARE     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pcF,
    input  logic                branchF,
    input  logic [PC_WIDTH-1:0] targetF,
    input  logic                stall,
    input  logic                flush,
    input  logic                branchD,
    input  logic                takenBranchD,
    output logic                prediction,
    output logic [PC_WIDTH-1:0] nextPC,
    output logic                predictionD,
    output logic                cpcSignal,
    output logic [PC_WIDTH-1:0] cpc
);
    logic [INDEX_BITS-1:0] idx_f, idx_q;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [PC_WIDTH-1:0]   fall_f, fall_q, target_q;
    logic                  pred_q, train;
    cnt_t                  cnt_f;

    branch_history_table #(.INDEX_BITS(INDEX_BITS)) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx_i (idx_f),
        .rd_cnt_o (cnt_f),
        .we_i     (train),
        .wr_idx_i (idx_q),
        .taken_i  (takenBranchD)
    );

    always_comb begin
        fall_f      = pcF + PC_WIDTH'(PC_STEP);
        idx_f       = (GSHARE != 0) ? pcF[INDEX_BITS-1:0] ^ INDEX_BITS'(ghr_q) : pcF[INDEX_BITS-1:0];
        prediction  = branchF & cnt_f[1];
        predictionD = pred_q;
        cpcSignal   = branchD & (takenBranchD ^ pred_q);
        cpc         = pred_q ? fall_q : target_q;
        nextPC      = cpcSignal ? cpc : (prediction ? targetF : fall_f);
        train       = branchD & ~stall;
        // Truncating cast keeps the newest GHR_BITS outcomes, valid down to GHR_BITS == 1.
        ghr_d       = GHR_BITS'({ghr_q, takenBranchD});
    end

    always_ff @(posedge clk) begin
        if (reset) ghr_q <= '0;
        else if (train) ghr_q <= ghr_d;
    end

    // D register: stall holds (beats flush), flush squashes the wrong-path fetch.
    always_ff @(posedge clk) begin
        if (reset || (!stall && flush)) begin
            pred_q   <= 1'b0;
            idx_q    <= '0;
            target_q <= '0;
            fall_q   <= '0;
        end else if (!stall) begin
            pred_q   <= prediction;
            idx_q    <= idx_f;
            target_q <= targetF;
            fall_q   <= fall_f;
        end
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side dynamic branch predictor for the pipelined core. It supplies the taken/not-taken prediction and next PC in F and carries the prediction into D, where the hazard logic consumes `predictionD`. When the branch resolves in D it provides the correction PC and trains a gshare-indexed table of 2-bit saturating counters. The PC register and instruction memory stay in the fetch stage; this block only computes `nextPC`.

## Interface
- `PC_WIDTH`, default 32: PC width.
- `PC_STEP`, default 1: sequential increment (word-addressed instruction memory).
- `INDEX_BITS`, default 6: table has 2^INDEX_BITS counters.
- `GHR_BITS`, default 4: global history length; must satisfy 1 ≤ GHR_BITS ≤ INDEX_BITS.
- `GSHARE`, default 1: 1 means index = pcF[INDEX_BITS-1:0] XOR zero-extended GHR; 0 means index = pcF[INDEX_BITS-1:0].

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `pcF`, in, PC_WIDTH: fetch PC.
- `branchF`, in, 1: fetch instruction is a conditional branch (predecode).
- `targetF`, in, PC_WIDTH: predecoded branch target.
- `stall`, in, 1: hold the D register and suppress training.
- `flush`, in, 1: clear the D register.
- `branchD`, in, 1: D instruction is a branch; resolution is valid.
- `takenBranchD`, in, 1: resolved outcome in D.
- `prediction`, out, 1: F-stage prediction.
- `nextPC`, out, PC_WIDTH: PC to load into the fetch PC register.
- `predictionD`, out, 1: prediction carried to D.
- `cpcSignal`, out, 1: mispredict in D.
- `cpc`, out, PC_WIDTH: correction PC.

## Operation
- **F read:** `prediction` = `branchF` & counter[idxF][1]. This is combinational.
- **D register:** per clock, loads {`prediction`, idxF, `targetF`, `pcF`+`PC_STEP`}.
  - `stall`=1: holds.
  - `stall`=0, `flush`=1: loads zeros.
  - `stall` has priority over `flush`.
- **Mispredict:** `cpcSignal` = `branchD` & (`takenBranchD` ^ `predictionD`).
- **Correction PC:** `cpc` = `predictionD` ? fallthroughD : targetD.
- **Next PC, in priority order:**
  1. `cpcSignal` selects `cpc`.
  2. Otherwise `prediction` selects `targetF`.
  3. Otherwise `pcF`+`PC_STEP`.
- **Training:** when `branchD` & ~`stall`, update counter[idxD] and shift the GHR.
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
  - GHR update: GHR ← {GHR[GHR_BITS-2:0], `takenBranchD`}. This is non-speculative, at resolution only.
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Same-index conflict:** F read and D write to the same index in one cycle return the old value; there is no bypass.
- **Width rule:** PC arithmetic wraps modulo 2^PC_WIDTH.

## Timing
- **Reset values:**
  - All counters 01.
  - GHR 0.
  - D register zeros, so `predictionD`=0 and `cpcSignal`=0.
  - Combinational outputs follow from these.
- **Reset mid-operation:** discards all training in one cycle.
- **Latency:** F→D is 1 cycle. A trained counter value is visible to the F read on the cycle after the update edge.
- **Combinational outputs:** `prediction`, `nextPC`, `cpc`, `cpcSignal`; no internal loops.
- **Stalled branch:** a branch held in D under `stall` trains exactly once, on the first non-stalled cycle.
- **`flush` with training:** simultaneous `flush` and a valid resolution train normally; `flush` only clears the wrong-path F instruction entering D.

## Structure
- **Shared package** `bp_pkg`:
  - Counter encoding constants `CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`.
  - Counter width 2 and its reset value.
- **Sub-module** `branch_history_table`:
  - Register array of 2-bit counters.
  - One async read port, one sync write port with saturating update logic.
  - Sync reset to `CNT_WNT`.
- **Top level:** index hash, GHR, D register, PC muxing.

## Test plan
- **Reset default** (`GSHARE`=0): after reset, `branchF`=1, `pcF`=0x10, `targetF`=0x40 → `prediction`=0, `nextPC`=0x11; next cycle `predictionD`=0.
- **Training to taken** (`GSHARE`=0): resolve two taken branches at index 0x10 (`branchD`=1, `takenBranchD`=1) → counter 01→10→11; fetch at 0x10 gives `prediction`=1, `nextPC`=0x40.
- **Mispredict correction:** `predictionD`=1, fallthroughD=0x11, `takenBranchD`=0 → `cpcSignal`=1, `cpc`=0x11, `nextPC`=0x11; counter 11→10.
- **Saturation** (`GSHARE`=0): three not-taken resolutions at a counter of 00 → counter stays 00; four taken from 01 → ends at 11.
- **Stall during resolution:** `stall`=1 for 3 cycles with `branchD`=1 → D register unchanged, no update; after release, counter changes by exactly 1 and GHR shifts by exactly 1 bit. With `stall`=1 and `flush`=1 together, the D register holds.
- **Reset mid-operation** (`GSHARE`=1): train a GHR pattern, then assert `reset` for 1 cycle → GHR=0, all fetches predict 0, `predictionD`=0.
